// File: rtl/wb_addr_decoder_pkg.sv
// Shared definitions for the Wishbone address decoder: state encodings,
// sizing helpers and the default SoC memory map.
package wb_addr_decoder_pkg;

  localparam logic [1:0] WB_IDLE = 2'd0;
  localparam logic [1:0] WB_BUSY = 2'd1;
  localparam logic [1:0] WB_ERR  = 2'd2;

  // bootrom, internal RAM, IO block A, IO block B (slave 0 in the low word)
  localparam int          DEF_NSLAVES = 4;
  localparam logic [127:0] DEF_BASE = {32'hc000_1000, 32'hc000_0000, 32'hb000_8000, 32'hb000_0000};
  localparam logic [127:0] DEF_MASK = {32'hffff_f000, 32'hffff_f000, 32'hffff_8000, 32'hffff_8000};

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  // index width that never collapses to zero bits
  function automatic int idx_w(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_addr_match.sv
// Base/mask window compare with lowest-index priority; purely combinational
// so it can be shared by other bridges that need the same memory map.
module wb_addr_match
  import wb_addr_decoder_pkg::*;
#(
  parameter int                    NSLAVES = DEF_NSLAVES,
  parameter int                    AW      = 32,
  parameter int                    IW      = idx_w(NSLAVES),
  parameter logic [NSLAVES*AW-1:0] BASE    = '0,
  parameter logic [NSLAVES*AW-1:0] MASK    = '0
)(
  input  logic [AW-1:0] addr,
  output logic          hit,
  output logic [IW-1:0] idx
);

  logic [NSLAVES-1:0] match;

  for (genvar i = 0; i < NSLAVES; i++) begin : g_cmp
    assign match[i] = (addr & MASK[i*AW +: AW]) == BASE[i*AW +: AW];
  end

  // scan downward so the lowest matching window is the last one written
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NSLAVES - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit = 1'b1;
        idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/wb_addr_decoder.sv
// One-master / N-slave pipelined Wishbone decoder with one transaction in
// flight, bus error on unmapped access or slave timeout, sticky fault record.
module wb_addr_decoder
  import wb_addr_decoder_pkg::*;
#(
  parameter int                    NSLAVES    = DEF_NSLAVES,
  parameter int                    AW         = 32,
  parameter int                    DW         = 32,
  parameter logic [NSLAVES*AW-1:0] SLAVE_BASE = DEF_BASE,
  parameter logic [NSLAVES*AW-1:0] SLAVE_MASK = DEF_MASK,
  parameter int                    TIMEOUT    = 255
)(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_wb_cyc,
  input  logic                  i_wb_stb,
  input  logic                  i_wb_we,
  input  logic [AW-1:0]         i_wb_addr,
  input  logic [DW-1:0]         i_wb_data,
  output logic [DW-1:0]         o_wb_data,
  output logic                  o_wb_stall,
  output logic                  o_wb_ack,
  output logic                  o_wb_err,
  output logic [NSLAVES-1:0]    o_s_stb,
  output logic                  o_s_we,
  output logic [AW-1:0]         o_s_addr,
  output logic [DW-1:0]         o_s_data,
  input  logic [NSLAVES*DW-1:0] i_s_data,
  input  logic [NSLAVES-1:0]    i_s_stall,
  input  logic [NSLAVES-1:0]    i_s_ack,
  output logic                  o_exception,
  output logic [AW-1:0]         o_fault_addr,
  input  logic                  i_exc_clear
);

  localparam int IW = idx_w(NSLAVES);
  localparam int TW = (TIMEOUT > 0) ? clog2(TIMEOUT + 1) : 1;

  logic [1:0]    state;
  logic [IW-1:0] sel;
  logic [TW-1:0] timer;
  logic [AW-1:0] req_addr;
  logic          err_q;
  logic          req, hit, expire;
  logic [IW-1:0] idx;

  wb_addr_match #(
    .NSLAVES (NSLAVES),
    .AW      (AW),
    .IW      (IW),
    .BASE    (SLAVE_BASE),
    .MASK    (SLAVE_MASK)
  ) u_match (
    .addr (i_wb_addr),
    .hit  (hit),
    .idx  (idx)
  );

  assign req      = i_wb_cyc & i_wb_stb;
  assign expire   = (TIMEOUT != 0) && (timer == TW'(TIMEOUT - 1));
  assign o_s_we   = i_wb_we;
  assign o_s_addr = i_wb_addr;
  assign o_s_data = i_wb_data;
  // a master that drops cyc during ERR has abandoned the cycle: no err seen
  assign o_wb_err = err_q & i_wb_cyc;

  always_comb begin
    o_s_stb    = '0;
    o_wb_stall = 1'b1;
    o_wb_ack   = 1'b0;
    o_wb_data  = '0;
    if (reset) begin
      case (state)
        WB_IDLE: begin
          o_wb_stall = req & hit & i_s_stall[idx];
          if (req & hit) o_s_stb[idx] = 1'b1;
        end
        WB_BUSY: begin
          o_wb_ack  = i_wb_cyc & i_s_ack[sel];
          o_wb_data = i_s_data[sel*DW +: DW];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= WB_IDLE;
      sel      <= '0;
      timer    <= '0;
      req_addr <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        WB_IDLE: begin
          if (req) begin
            req_addr <= i_wb_addr;
            timer    <= '0;
            if (!hit) begin
              state <= WB_ERR;
              err_q <= 1'b1;
            end else if (!i_s_stall[idx]) begin
              sel   <= idx;
              state <= WB_BUSY;
            end
          end
        end
        WB_BUSY: begin
          // abort beats ack, ack beats expiry
          if (!i_wb_cyc || i_s_ack[sel]) begin
            state <= WB_IDLE;
            timer <= '0;
          end else if (expire) begin
            state <= WB_ERR;
            err_q <= 1'b1;
            timer <= '0;
          end else if (timer != {TW{1'b1}}) begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= WB_IDLE;
      endcase
    end
  end

  // the fault is recorded even if the master drops cyc during ERR; a new
  // fault outranks a clear arriving in the same cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_exception  <= 1'b0;
      o_fault_addr <= '0;
    end else if (state == WB_ERR) begin
      o_exception <= 1'b1;
      if (!o_exception || i_exc_clear) o_fault_addr <= req_addr;
    end else if (i_exc_clear) begin
      o_exception  <= 1'b0;
      o_fault_addr <= '0;
    end
  end

endmodule

// File: tb/tb_wb_addr_decoder.sv
// Self-checking bench for wb_addr_decoder: directed scenarios plus randomized
// transactions checked against a transaction-level model of the memory map.
module tb_wb_addr_decoder;
  localparam int NS = 4, AW = 32, DW = 32;
  localparam logic [AW-1:0] MB [NS] = '{32'hb000_0000, 32'hb000_8000, 32'hc000_0000, 32'hc000_1000};
  localparam logic [AW-1:0] MM [NS] = '{32'hffff_8000, 32'hffff_8000, 32'hffff_f000, 32'hffff_f000};

  logic clk = 1'b0, rst_n = 1'b0;
  logic cyc, stb, we, exc_clear;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata, ov_rdata;
  logic stall, ack, err, s_we, exc, ov_stall, ov_ack, ov_err, ov_s_we, ov_exc;
  logic [NS-1:0] s_stb, ov_s_stb, s_stall, s_ack;
  logic [AW-1:0] s_addr, fault, ov_s_addr, ov_fault;
  logic [DW-1:0] s_wdata, ov_s_wdata;
  logic [NS*DW-1:0] s_rdata;

  int nvec = 0, nerr = 0;
  logic model_exc;
  logic [AW-1:0] model_fault;

  always #5 clk = ~clk;

  wb_addr_decoder dut (
    .clk(clk), .reset(rst_n), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_addr(addr), .i_wb_data(wdata), .o_wb_data(rdata), .o_wb_stall(stall),
    .o_wb_ack(ack), .o_wb_err(err), .o_s_stb(s_stb), .o_s_we(s_we), .o_s_addr(s_addr),
    .o_s_data(s_wdata), .i_s_data(s_rdata), .i_s_stall(s_stall), .i_s_ack(s_ack),
    .o_exception(exc), .o_fault_addr(fault), .i_exc_clear(exc_clear)
  );

  // slave 0 window covers the whole address space
  wb_addr_decoder #(
    .SLAVE_BASE({32'hc000_1000, 32'hc000_0000, 32'hb000_8000, 32'h0000_0000}),
    .SLAVE_MASK({32'hffff_f000, 32'hffff_f000, 32'hffff_8000, 32'h0000_0000})
  ) dut_ov (
    .clk(clk), .reset(rst_n), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_addr(addr), .i_wb_data(wdata), .o_wb_data(ov_rdata), .o_wb_stall(ov_stall),
    .o_wb_ack(ov_ack), .o_wb_err(ov_err), .o_s_stb(ov_s_stb), .o_s_we(ov_s_we), .o_s_addr(ov_s_addr),
    .o_s_data(ov_s_wdata), .i_s_data(s_rdata), .i_s_stall(s_stall), .i_s_ack(s_ack),
    .o_exception(ov_exc), .o_fault_addr(ov_fault), .i_exc_clear(exc_clear)
  );

  function automatic int model_sel(input logic [AW-1:0] a);
    for (int i = 0; i < NS; i++) if ((a & MM[i]) == MB[i]) return i;
    return -1;
  endfunction

  function automatic logic [NS-1:0] onehot(input int i);
    logic [NS-1:0] r;
    r = '0;
    if (i >= 0) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [AW-1:0] gen_addr();
    int k;
    k = $urandom_range(0, 5);
    if (k < NS) return MB[k] | (AW'($urandom) & ~MM[k]);
    return AW'($urandom);
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive_idle();
    cyc = 0; stb = 0; we = 0; addr = '0; wdata = '0; exc_clear = 0;
    s_rdata = '0; s_stall = '0; s_ack = '0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 0; cyc = 1; stb = 1; addr = 32'hb000_0000; s_ack = '1;
    #2;
    nvec++; if (stall !== 1'b1) begin nerr++; $display("FAIL rst_stall got=%0h exp=1", stall); end
    nvec++; if (s_stb !== 4'b0) begin nerr++; $display("FAIL rst_stb got=%0h exp=0", s_stb); end
    nvec++; if (ack !== 1'b0) begin nerr++; $display("FAIL rst_ack got=%0h exp=0", ack); end
    nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL rst_err got=%0h exp=0", err); end
    nvec++; if (exc !== 1'b0 || fault !== 32'h0) begin nerr++; $display("FAIL rst_exc got=%0h/%h exp=0/0", exc, fault); end
    drive_idle();
    repeat (2) tick();
    rst_n = 1; model_exc = 0; model_fault = '0;
    tick(); #1;
    nvec++; if (stall !== 1'b0 || s_stb !== 4'b0) begin nerr++; $display("FAIL idle_noreq got=%0h/%0h exp=0/0", stall, s_stb); end
  endtask

  task automatic test_decode();
    logic [AW-1:0] a;
    for (int n = 0; n < 24; n++) begin
      a = (n == 0) ? 32'h8000_0000 : gen_addr();
      addr = a; cyc = 1; stb = 1; s_stall = '0;
      #1;
      nvec++; if (s_stb !== onehot(model_sel(a))) begin nerr++; $display("FAIL decode a=%h got=%0h exp=%0h", a, s_stb, onehot(model_sel(a))); end
      nvec++; if (ov_s_stb !== 4'b0001) begin nerr++; $display("FAIL overlap a=%h got=%0h exp=1", a, ov_s_stb); end
      nvec++; if (stall !== 1'b0) begin nerr++; $display("FAIL decode_stall a=%h got=%0h exp=0", a, stall); end
      cyc = 0; stb = 0;
      tick();
    end
  endtask

  task automatic test_read();
    addr = 32'hb000_0010; cyc = 1; stb = 1; we = 0;
    #1;
    nvec++; if (s_stb !== 4'b0001 || stall !== 1'b0) begin nerr++; $display("FAIL rd_req got=%0h/%0h exp=1/0", s_stb, stall); end
    tick(); stb = 0; #1;
    nvec++; if (s_stb !== 4'b0 || stall !== 1'b1 || ack !== 1'b0) begin nerr++; $display("FAIL rd_busy got=%0h/%0h/%0h exp=0/1/0", s_stb, stall, ack); end
    tick(); s_rdata[31:0] = 32'h1234_5678; s_ack[0] = 1; #1;
    nvec++; if (ack !== 1'b1 || rdata !== 32'h1234_5678) begin nerr++; $display("FAIL rd_ack got=%0h/%h exp=1/12345678", ack, rdata); end
    tick(); s_ack = '0; cyc = 0; #1;
    nvec++; if (ack !== 1'b0 || rdata !== 32'h0) begin nerr++; $display("FAIL rd_after got=%0h/%h exp=0/0", ack, rdata); end
  endtask

  task automatic test_stall_write();
    addr = 32'hb000_8004; wdata = 32'hdead_beef; we = 1; cyc = 1; stb = 1; s_stall[1] = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      nvec++; if (s_stb !== 4'b0010 || stall !== 1'b1) begin nerr++; $display("FAIL wr_stall k=%0d got=%0h/%0h exp=2/1", k, s_stb, stall); end
      nvec++; if (s_we !== 1'b1 || s_wdata !== 32'hdead_beef || s_addr !== 32'hb000_8004) begin nerr++; $display("FAIL wr_bcast got=%0h/%h/%h", s_we, s_wdata, s_addr); end
      tick();
    end
    s_stall[1] = 0; #1;
    nvec++; if (s_stb !== 4'b0010 || stall !== 1'b0) begin nerr++; $display("FAIL wr_accept got=%0h/%0h exp=2/0", s_stb, stall); end
    tick(); stb = 0; s_ack[1] = 1; #1;
    nvec++; if (ack !== 1'b1) begin nerr++; $display("FAIL wr_ack got=%0h exp=1", ack); end
    tick(); s_ack = '0; cyc = 0; we = 0; #1;
    nvec++; if (ack !== 1'b0) begin nerr++; $display("FAIL wr_after got=%0h exp=0", ack); end
  endtask

  task automatic test_unmapped(input logic [AW-1:0] a, input logic clr);
    addr = a; cyc = 1; stb = 1;
    #1;
    nvec++; if (s_stb !== 4'b0 || stall !== 1'b0) begin nerr++; $display("FAIL um_req a=%h got=%0h/%0h exp=0/0", a, s_stb, stall); end
    tick(); stb = 0; exc_clear = clr; #1;
    nvec++; if (err !== 1'b1 || stall !== 1'b1 || ack !== 1'b0) begin nerr++; $display("FAIL um_err a=%h got=%0h/%0h/%0h exp=1/1/0", a, err, stall, ack); end
    if (!model_exc || clr) model_fault = a;
    model_exc = 1;
    tick(); exc_clear = 0; #1;
    nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL um_pulse got=%0h exp=0", err); end
    nvec++; if (exc !== model_exc || fault !== model_fault) begin nerr++; $display("FAIL um_exc got=%0h/%h exp=%0h/%h", exc, fault, model_exc, model_fault); end
    cyc = 0;
  endtask

  task automatic test_clear();
    exc_clear = 1; tick(); exc_clear = 0; #1;
    model_exc = 0; model_fault = '0;
    nvec++; if (exc !== 1'b0 || fault !== 32'h0) begin nerr++; $display("FAIL clear got=%0h/%h exp=0/0", exc, fault); end
  endtask

  task automatic test_timeout();
    int e;
    logic found;
    addr = 32'hc000_0000; cyc = 1; stb = 1;
    #1;
    nvec++; if (s_stb !== 4'b0100) begin nerr++; $display("FAIL to_req got=%0h exp=4", s_stb); end
    tick(); stb = 0;
    e = 0; found = 0;
    while (!found && e < 300) begin
      #1;
      if (err === 1'b1) found = 1;
      else begin tick(); e++; end
    end
    nvec++; if (!found || e != 255) begin nerr++; $display("FAIL to_delay got=%0d found=%0d exp=255", e, found); end
    if (!model_exc) model_fault = 32'hc000_0000;
    model_exc = 1;
    tick(); #1;
    nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL to_pulse got=%0h exp=0", err); end
    repeat (4) tick();
    s_ack[2] = 1; #1;
    nvec++; if (ack !== 1'b0 || rdata !== 32'h0) begin nerr++; $display("FAIL to_late got=%0h/%h exp=0/0", ack, rdata); end
    tick(); s_ack = '0; #1;
    nvec++; if (exc !== model_exc || fault !== model_fault) begin nerr++; $display("FAIL to_exc got=%0h/%h exp=%0h/%h", exc, fault, model_exc, model_fault); end
    cyc = 0;
  endtask

  task automatic test_abort();
    addr = 32'hb000_8000; cyc = 1; stb = 1;
    tick(); stb = 0; cyc = 0; s_ack[1] = 1; #1;
    nvec++; if (ack !== 1'b0) begin nerr++; $display("FAIL ab_busy got=%0h exp=0", ack); end
    tick(); #1;
    nvec++; if (ack !== 1'b0 || stall !== 1'b0) begin nerr++; $display("FAIL ab_idle got=%0h/%0h exp=0/0", ack, stall); end
    s_ack = '0;
    addr = 32'h8000_0004; cyc = 1; stb = 1;
    tick(); stb = 0; cyc = 0; #1;
    nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL ab_err got=%0h exp=0", err); end
    if (!model_exc) model_fault = 32'h8000_0004;
    model_exc = 1;
    tick(); #1;
    nvec++; if (exc !== model_exc || fault !== model_fault) begin nerr++; $display("FAIL ab_exc got=%0h/%h exp=%0h/%h", exc, fault, model_exc, model_fault); end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int i, nst, dly;
    test_clear();
    for (int n = 0; n < 40; n++) begin
      a = gen_addr(); i = model_sel(a);
      if (i < 0) test_unmapped(a, 1'b0);
      else begin
        nst = $urandom_range(0, 2); dly = $urandom_range(0, 3); d = $urandom;
        we = 1'($urandom); wdata = $urandom; addr = a; cyc = 1; stb = 1;
        for (int k = 0; k <= nst; k++) begin
          s_stall[i] = (k < nst);
          #1;
          nvec++; if (s_stb !== onehot(i) || stall !== (k < nst)) begin nerr++; $display("FAIL rnd_req a=%h got=%0h/%0h exp=%0h/%0h", a, s_stb, stall, onehot(i), k < nst); end
          tick();
        end
        stb = 0;
        for (int k = 0; k < dly; k++) begin
          s_ack = onehot((i + 1) % NS);
          #1;
          nvec++; if (ack !== 1'b0 || stall !== 1'b1) begin nerr++; $display("FAIL rnd_wait a=%h got=%0h/%0h exp=0/1", a, ack, stall); end
          tick();
        end
        s_rdata = {$urandom, $urandom, $urandom, $urandom};
        s_rdata[i*DW +: DW] = d; s_ack = onehot(i);
        #1;
        nvec++; if (ack !== 1'b1 || rdata !== d) begin nerr++; $display("FAIL rnd_ack a=%h got=%0h/%h exp=1/%h", a, ack, rdata, d); end
        tick(); s_ack = '0; cyc = 0; we = 0;
      end
    end
    #1;
    nvec++; if (exc !== model_exc || fault !== model_fault) begin nerr++; $display("FAIL rnd_exc got=%0h/%h exp=%0h/%h", exc, fault, model_exc, model_fault); end
  endtask

  task automatic test_reset_mid_busy();
    addr = 32'hc000_1000; cyc = 1; stb = 1;
    tick(); stb = 0; #1;
    rst_n = 0; s_ack[3] = 1; #1;
    model_exc = 0; model_fault = '0;
    nvec++; if (ack !== 1'b0 || stall !== 1'b1 || s_stb !== 4'b0 || err !== 1'b0) begin nerr++; $display("FAIL mid_rst got=%0h/%0h/%0h/%0h exp=0/1/0/0", ack, stall, s_stb, err); end
    nvec++; if (exc !== model_exc || fault !== model_fault) begin nerr++; $display("FAIL mid_rst_exc got=%0h/%h exp=0/0", exc, fault); end
    tick(); rst_n = 1;
    tick(); #1;
    nvec++; if (ack !== 1'b0 || rdata !== 32'h0) begin nerr++; $display("FAIL mid_release got=%0h/%h exp=0/0", ack, rdata); end
    s_ack = '0; cyc = 0;
  endtask

  initial begin
    model_exc = 0; model_fault = '0;
    test_reset();
    test_decode();
    test_read();
    test_stall_write();
    test_unmapped(32'h8000_0000, 1'b0);
    test_unmapped(32'h9000_0000, 1'b0);
    test_clear();
    test_unmapped(32'h9000_0000, 1'b1);
    test_timeout();
    test_abort();
    test_random();
    test_reset_mid_busy();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
